vec_offset_stream: RTL and testbench

//  Parametrised N-lane vector offset adder; next generation of the fixed 9-lane +100 block.

---
 rtl/vec_offset_stream.sv | 139 +++++++++++++
 tb/tb_vec_offset_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_offset_stream.sv
// vec_offset_stream: N-lane vector offset adder with a valid/ready handshake on
// both sides and a DEPTH-entry output FIFO.
//
// Each accepted beat adds 'offset' to every lane at WIDTH+1 bits. The carry
// becomes the per-lane ovf flag, and the lane result plus its flags are pushed
// into the FIFO. The FIFO head is presented on out_a/out_ovf. Both outputs read
// zero while the FIFO is empty.
//
// Optional feature macro: VEC_OFFSET_SAT_EN
//   defined   - lanes that carry out store 2^WIDTH-1 (clamp); out_ovf still
//               reports the carry
//   undefined - lanes wrap modulo 2^WIDTH; no clamp logic is built
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   input beat valid
//   in_ready   out  block can accept a beat (registered occupancy < DEPTH)
//   in_a       in   input lanes, lane i at [i*WIDTH +: WIDTH]
//   offset     in   unsigned offset, sampled with each accepted beat
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts head
//   out_a      out  head result lanes (zero when empty)
//   out_ovf    out  head per-lane carry flags (zero when empty)
//   beat_count out  accepted-beat counter, wraps at 2^CNT_W

module vec_offset_stream #(
  parameter int unsigned N_LANES = 9,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_LANES*WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]           offset,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_LANES*WIDTH-1:0]   out_a,
  output logic [N_LANES-1:0]         out_ovf,
  output logic [CNT_W-1:0]           beat_count
);

  localparam int unsigned VEC_W = N_LANES * WIDTH;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [VEC_W-1:0]   data_q [DEPTH];
  logic [N_LANES-1:0] ovf_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               push_c;
  logic               pop_c;
  logic [VEC_W-1:0]   res_c;
  logic [N_LANES-1:0] lane_ovf_c;

  // Handshake status comes from registered occupancy only, so out_ready never
  // reaches in_ready combinationally. A full FIFO refuses a push even when it
  // pops in the same cycle.
  assign in_ready  = (occ_q < OCC_FULL);
  assign out_valid = (occ_q != '0);
  assign push_c    = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;

  // Per-lane add at WIDTH+1 bits; the top bit is the carry flag.
  always_comb begin : lane_add
    logic [WIDTH:0] sum;
    sum        = '0;
    res_c      = '0;
    lane_ovf_c = '0;
    for (int i = 0; i < int'(N_LANES); i++) begin
      sum = {1'b0, in_a[i*WIDTH +: WIDTH]} + {1'b0, offset};
      lane_ovf_c[i] = sum[WIDTH];
`ifdef VEC_OFFSET_SAT_EN
      res_c[i*WIDTH +: WIDTH] = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
      res_c[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
`endif
    end
  end

  // Pointer, occupancy and counter next-state. Pointers wrap explicitly, so
  // DEPTH does not have to be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (push_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      cnt_d    = cnt_q + CNT_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push_c && pop_c) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Control state. A reset flushes the FIFO and drops any handshake in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage. It needs no reset because out_a/out_ovf are gated by
  // out_valid.
  always_ff @(posedge clock) begin
    if (push_c) begin
      data_q[wr_ptr_q] <= res_c;
      ovf_q[wr_ptr_q]  <= lane_ovf_c;
    end
  end

  assign out_a      = out_valid ? data_q[rd_ptr_q] : '0;
  assign out_ovf    = out_valid ? ovf_q[rd_ptr_q]  : '0;
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_vec_offset_stream.sv
// Directed bench for vec_offset_stream (N_LANES=9, WIDTH=8, DEPTH=2).
// A second instance with CNT_W=4 shares all inputs and covers the counter wrap.

module tb_vec_offset_stream;

  localparam int unsigned NL = 9;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = NL * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_a;
  logic [W-1:0]  offset;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] out_a;
  logic [NL-1:0] out_ovf;
  logic [15:0]   beat_count;

  logic          w_in_ready;
  logic          w_out_valid;
  logic [NW-1:0] w_out_a;
  logic [NL-1:0] w_out_ovf;
  logic [3:0]    w_beat_count;

  int errors = 0;
  int checks = 0;

  vec_offset_stream #(.N_LANES(NL), .WIDTH(W), .DEPTH(2), .CNT_W(16)) u_dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .offset(offset), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_ovf(out_ovf), .beat_count(beat_count)
  );

  vec_offset_stream #(.N_LANES(NL), .WIDTH(W), .DEPTH(2), .CNT_W(4)) u_dut_w (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .offset(offset), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_a(w_out_a), .out_ovf(w_out_ovf), .beat_count(w_beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds a beat whose lane i holds s+i.
  function automatic logic [NW-1:0] seq(input int s);
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NL); i++) v[i*W +: W] = W'(s + i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = seq(7); offset = 8'd9; out_ready = 1'b0;
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_a !== '0) begin errors++; $display("FAIL reset_out_a: got %h expected 0", out_a); end
    checks++; if (out_ovf !== '0) begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
    checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL reset_beat_count: got %0d expected 0", beat_count); end
    checks++; if (w_beat_count !== 4'd0) begin errors++; $display("FAIL reset_w_beat_count: got %0d expected 0", w_beat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_after: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    in_a = seq(0); offset = 8'd100; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_a !== seq(100)) begin errors++; $display("FAIL basic_out_a: got %h expected %h", out_a, seq(100)); end
    checks++; if (out_ovf !== '0) begin errors++; $display("FAIL basic_out_ovf: got %b expected 0", out_ovf); end
    checks++; if (beat_count !== 16'd1) begin errors++; $display("FAIL basic_beat_count: got %0d expected 1", beat_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid: got %b expected 0", out_valid); end
    checks++; if (out_a !== '0) begin errors++; $display("FAIL basic_empty_out_a: got %h expected 0", out_a); end
  endtask

  task automatic test_overflow();
    logic [NW-1:0] v;
    logic [NW-1:0] e1;
    logic [NW-1:0] e2;
    v = '0;
    v[0*W +: W] = 8'd200; v[1*W +: W] = 8'd155; v[2*W +: W] = 8'd156;
    e1 = '0;
    for (int i = 3; i < int'(NL); i++) e1[i*W +: W] = 8'd100;
`ifdef VEC_OFFSET_SAT_EN
    e1[0*W +: W] = 8'd255; e1[1*W +: W] = 8'd255; e1[2*W +: W] = 8'd255;
`else
    e1[0*W +: W] = 8'd44;  e1[1*W +: W] = 8'd255; e1[2*W +: W] = 8'd0;
`endif
    // Second beat: lanes 0..8 plus 255, so lane 0 is 255 and lanes 1..8 carry.
    e2 = '0;
    e2[0*W +: W] = 8'd255;
`ifdef VEC_OFFSET_SAT_EN
    for (int i = 1; i < int'(NL); i++) e2[i*W +: W] = 8'd255;
`else
    for (int i = 1; i < int'(NL); i++) e2[i*W +: W] = W'(i - 1);
`endif
    do_reset();
    in_a = v; offset = 8'd100; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_a = seq(0); offset = 8'd255;
    checks++; if (out_a !== e1) begin errors++; $display("FAIL ovf_out_a: got %h expected %h", out_a, e1); end
    checks++; if (out_ovf !== 9'b000000101) begin errors++; $display("FAIL ovf_out_ovf: got %b expected 000000101", out_ovf); end
    step();
    in_valid = 1'b0;
    checks++; if (out_a !== e2) begin errors++; $display("FAIL ovf_max_out_a: got %h expected %h", out_a, e2); end
    checks++; if (out_ovf !== 9'b111111110) begin errors++; $display("FAIL ovf_max_out_ovf: got %b expected 111111110", out_ovf); end
    checks++; if (beat_count !== 16'd2) begin errors++; $display("FAIL ovf_beat_count: got %0d expected 2", beat_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0; offset = 8'd1; in_valid = 1'b1; in_a = seq(10);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_empty: got %b expected 1", in_ready); end
    step();
    in_a = seq(20);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b expected 1", in_ready); end
    step();
    in_a = seq(30);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
    checks++; if (out_a !== seq(11)) begin errors++; $display("FAIL bp_head_a: got %h expected %h", out_a, seq(11)); end
    checks++; if (beat_count !== 16'd2) begin errors++; $display("FAIL bp_count_full: got %0d expected 2", beat_count); end
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b expected 0", in_ready); end
    checks++; if (beat_count !== 16'd2) begin errors++; $display("FAIL bp_count_held: got %0d expected 2", beat_count); end
    checks++; if (out_a !== seq(11)) begin errors++; $display("FAIL bp_head_held: got %h expected %h", out_a, seq(11)); end
    out_ready = 1'b1;
    step();
    checks++; if (out_a !== seq(21)) begin errors++; $display("FAIL bp_second_a: got %h expected %h", out_a, seq(21)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); end
    checks++; if (beat_count !== 16'd2) begin errors++; $display("FAIL bp_count_no_push_on_full: got %0d expected 2", beat_count); end
    step();
    in_valid = 1'b0;
    checks++; if (out_a !== seq(31)) begin errors++; $display("FAIL bp_third_a: got %h expected %h", out_a, seq(31)); end
    checks++; if (beat_count !== 16'd3) begin errors++; $display("FAIL bp_count_third: got %0d expected 3", beat_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; offset = 8'd3;
    for (int k = 0; k < 20; k++) begin
      in_a = seq(k * 5);
      step();
      checks++; if (out_valid !== 1'b1 || out_a !== seq(k * 5 + 3)) begin
        errors++; $display("FAIL stream_beat%0d: got valid=%b a=%h expected valid=1 a=%h", k, out_valid, out_a, seq(k * 5 + 3));
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b expected 1", k, in_ready); end
    end
    in_valid = 1'b0;
    checks++; if (beat_count !== 16'd20) begin errors++; $display("FAIL stream_beat_count: got %0d expected 20", beat_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; offset = 8'd0; in_a = seq(40);
    step();
    in_a = seq(50);
    step();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_full: got ready=%b valid=%b expected ready=0 valid=1", in_ready, out_valid);
    end
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_a !== '0) begin errors++; $display("FAIL midrst_out_a: got %h expected 0", out_a); end
    checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL midrst_beat_count: got %0d expected 0", beat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    in_a = seq(60); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_a !== seq(60)) begin errors++; $display("FAIL midrst_next_a: got %h expected %h", out_a, seq(60)); end
    checks++; if (beat_count !== 16'd1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", beat_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_alone: got %b expected 0", out_valid); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; offset = 8'd0;
    for (int k = 0; k < 17; k++) begin
      in_a = seq(k);
      step();
    end
    in_valid = 1'b0;
    checks++; if (w_beat_count !== 4'd1) begin errors++; $display("FAIL wrap_w_beat_count: got %0d expected 1", w_beat_count); end
    checks++; if (beat_count !== 16'd17) begin errors++; $display("FAIL wrap_beat_count: got %0d expected 17", beat_count); end
    checks++; if (w_out_valid !== 1'b1 || w_out_a !== seq(16) || w_out_ovf !== '0) begin
      errors++; $display("FAIL wrap_w_head: got valid=%b a=%h ovf=%b expected valid=1 a=%h ovf=0", w_out_valid, w_out_a, w_out_ovf, seq(16));
    end
    checks++; if (w_in_ready !== 1'b1) begin errors++; $display("FAIL wrap_w_in_ready: got %b expected 1", w_in_ready); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; offset = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_streaming();
    test_mid_reset();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
